// File: rtl/d_flipflop_pkg.sv
// ---------------------------------------------------------------------------
// d_flipflop_pkg
// Shared definitions for the d_flipflop register primitive:
//   DFF_DEFAULT_WIDTH      - default data width
//   DFF_DEFAULT_RESET_VAL  - default per-bit reset/clear value
//   bit_edge_t / bit_edge  - per-bit rise/fall detection from old/new values
// ---------------------------------------------------------------------------
package d_flipflop_pkg;

    localparam int   DFF_DEFAULT_WIDTH     = 1;
    localparam logic DFF_DEFAULT_RESET_VAL = 1'b0;

    // Edge flags for one bit, packed so a caller can unpack it straight
    // into {rise, fall} with a concatenation.
    typedef struct packed {
        logic rise;
        logic fall;
    } bit_edge_t;

    function automatic bit_edge_t bit_edge(input logic old_bit, input logic new_bit);
        bit_edge_t e;
        e.rise = ~old_bit & new_bit;
        e.fall = old_bit & ~new_bit;
        return e;
    endfunction

endpackage

// File: rtl/d_flipflop_parity.sv
// ---------------------------------------------------------------------------
// d_flipflop_parity
// Parity guard for d_flipflop (only instantiated when D_FLIPFLOP_PARITY_EN
// is defined). Stores the parity of every value written into the register
// and flags a sticky error when the register's current contents no longer
// match the stored parity.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear (clears the error, reloads reset parity)
//   en          - load enable of the guarded register
//   d           - data being loaded into the guarded register
//   q           - current contents of the guarded register
//   parity_err  - registered, sticky parity error flag
// ---------------------------------------------------------------------------
module d_flipflop_parity #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic             parity_err
);

    logic par_reg;

    // Stored parity tracks exactly what the register was told to hold,
    // so a corrupted register bit shows up as a disagreement with ^q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_reg    <= ^RESET_VAL;
            parity_err <= 1'b0;
        end else if (clr) begin
            par_reg    <= ^RESET_VAL;
            parity_err <= 1'b0;
        end else begin
            if (en) begin
                par_reg <= ^d;
            end
            if ((^q) != par_reg) begin
                parity_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/d_flipflop.sv
// ---------------------------------------------------------------------------
// d_flipflop
// Parameterised rising-edge D register with load enable, synchronous clear,
// previous-value stage and per-bit rise/fall/change flags.
// Optional parity guard enabled by defining D_FLIPFLOP_PARITY_EN, which adds
// the parity_err output.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   D        - data to capture
//   en       - load enable (1 = capture D, 0 = hold)
//   clr      - synchronous clear to RESET_VAL, priority over en
//   Q        - registered data
//   Q_n      - bitwise complement of Q
//   q_prev   - value Q held before its most recent update
//   rise     - per-bit 0->1 flags for the last update
//   fall     - per-bit 1->0 flags for the last update
//   changed  - OR-reduction of rise|fall
//   parity_err (D_FLIPFLOP_PARITY_EN only) - sticky parity error
// ---------------------------------------------------------------------------
module d_flipflop
    import d_flipflop_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_DEFAULT_RESET_VAL}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic [WIDTH-1:0] q_prev,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
`ifdef D_FLIPFLOP_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    logic [WIDTH-1:0] q_reg,    q_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic [WIDTH-1:0] rise_reg, rise_next;
    logic [WIDTH-1:0] fall_reg, fall_next;

    // Next-state selection: clr beats en, and any update (even one that
    // rewrites the same value) refreshes q_prev. Flags only live for the
    // cycle after an update, so they default to zero.
    always_comb begin
        q_next    = q_reg;
        prev_next = prev_reg;
        rise_next = '0;
        fall_next = '0;
        if (clr) begin
            q_next = RESET_VAL;
        end else if (en) begin
            q_next = D;
        end
        if (clr || en) begin
            prev_next = q_reg;
            for (int i = 0; i < WIDTH; i++) begin
                {rise_next[i], fall_next[i]} = bit_edge(q_reg[i], q_next[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg    <= RESET_VAL;
            prev_reg <= RESET_VAL;
            rise_reg <= '0;
            fall_reg <= '0;
        end else begin
            q_reg    <= q_next;
            prev_reg <= prev_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    assign Q       = q_reg;
    assign Q_n     = ~q_reg;
    assign q_prev  = prev_reg;
    assign rise    = rise_reg;
    assign fall    = fall_reg;
    assign changed = |(rise_reg | fall_reg);

`ifdef D_FLIPFLOP_PARITY_EN
    d_flipflop_parity #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_parity (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .en         (en),
        .d          (D),
        .q          (q_reg),
        .parity_err (parity_err)
    );
`endif

endmodule

// File: tb/tb_d_flipflop.sv
// ---------------------------------------------------------------------------
// tb_d_flipflop
// Directed, table-driven bench for d_flipflop. One 1-bit and one 8-bit
// instance share clock, reset, en and clr; each table targets one of them.
// With D_FLIPFLOP_PARITY_EN defined, a corrupted register bit is injected
// and the sticky parity_err flag is checked.
// ---------------------------------------------------------------------------
module tb_d_flipflop;

    typedef struct {
        logic       en;
        logic       clr;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic [7:0] exp_prev;
        logic [7:0] exp_rise;
        logic [7:0] exp_fall;
        logic       exp_changed;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       d1;
    logic [7:0] d8;

    logic       q1, qn1, prev1, rise1, fall1, changed1;
    logic [7:0] q8, qn8, prev8, rise8, fall8;
    logic       changed8;
`ifdef D_FLIPFLOP_PARITY_EN
    logic       perr1, perr8;
    logic [7:0] bad_val;
`endif

    int total;
    int bad;

    vec_t vec1 [5];
    vec_t vec8 [9];

    d_flipflop #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .D       (d1),
        .en      (en),
        .clr     (clr),
        .Q       (q1),
        .Q_n     (qn1),
        .q_prev  (prev1),
        .rise    (rise1),
        .fall    (fall1),
        .changed (changed1)
`ifdef D_FLIPFLOP_PARITY_EN
        ,
        .parity_err (perr1)
`endif
    );

    d_flipflop #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .D       (d8),
        .en      (en),
        .clr     (clr),
        .Q       (q8),
        .Q_n     (qn8),
        .q_prev  (prev8),
        .rise    (rise8),
        .fall    (fall8),
        .changed (changed8)
`ifdef D_FLIPFLOP_PARITY_EN
        ,
        .parity_err (perr8)
`endif
    );

    // Rising edges at t=5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic sel8);
        en  = v.en;
        clr = v.clr;
        if (sel8) begin
            d8 = v.d;
            d1 = 1'b0;
        end else begin
            d1 = v.d[0];
            d8 = 8'h00;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input string tag, input vec_t v, input logic sel8);
        if (sel8) begin
            checkOutput({tag, "_q"},       q8,              v.exp_q);
            checkOutput({tag, "_qn"},      qn8,             ~v.exp_q);
            checkOutput({tag, "_prev"},    prev8,           v.exp_prev);
            checkOutput({tag, "_rise"},    rise8,           v.exp_rise);
            checkOutput({tag, "_fall"},    fall8,           v.exp_fall);
            checkOutput({tag, "_changed"}, {7'b0, changed8}, {7'b0, v.exp_changed});
        end else begin
            checkOutput({tag, "_q"},       {7'b0, q1},       {7'b0, v.exp_q[0]});
            checkOutput({tag, "_qn"},      {7'b0, qn1},      {7'b0, ~v.exp_q[0]});
            checkOutput({tag, "_prev"},    {7'b0, prev1},    {7'b0, v.exp_prev[0]});
            checkOutput({tag, "_rise"},    {7'b0, rise1},    {7'b0, v.exp_rise[0]});
            checkOutput({tag, "_fall"},    {7'b0, fall1},    {7'b0, v.exp_fall[0]});
            checkOutput({tag, "_changed"}, {7'b0, changed1}, {7'b0, v.exp_changed});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //             en    clr   d      q      prev   rise   fall   chg
        vec1[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vec1[1] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1};
        vec1[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1};
        vec1[3] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1};
        vec1[4] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};

        vec8[0] = '{1'b1, 1'b0, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b1};
        vec8[1] = '{1'b0, 1'b0, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
        vec8[2] = '{1'b0, 1'b0, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
        vec8[3] = '{1'b0, 1'b0, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
        vec8[4] = '{1'b1, 1'b0, 8'h3C, 8'h3C, 8'hA5, 8'h18, 8'h81, 1'b1};
        vec8[5] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h3C, 8'h00, 8'h3C, 1'b1};
        vec8[6] = '{1'b0, 1'b0, 8'h77, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0};
        vec8[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vec8[8] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1};

        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        d1    = 1'b0;
        d8    = 8'h00;

        // Reset state, observed before any clock edge.
        #1;
        checkOutput("rst_q1",      {7'b0, q1},       8'h00);
        checkOutput("rst_qn1",     {7'b0, qn1},      8'h01);
        checkOutput("rst_q8",      q8,               8'h00);
        checkOutput("rst_qn8",     qn8,              8'hFF);
        checkOutput("rst_prev8",   prev8,            8'h00);
        checkOutput("rst_rise8",   rise8,            8'h00);
        checkOutput("rst_fall8",   fall8,            8'h00);
        checkOutput("rst_changed", {7'b0, changed8}, 8'h00);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vec1[i], 1'b0);
            checkVector($sformatf("w1_v%0d", i), vec1[i], 1'b0);
        end

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vec8[i], 1'b1);
            checkVector($sformatf("w8_v%0d", i), vec8[i], 1'b1);
        end

        // Asynchronous reset between edges while Q=0xFF.
        checkOutput("pre_rst_q8", q8, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_q8",      q8,               8'h00);
        checkOutput("async_rst_qn8",     qn8,              8'hFF);
        checkOutput("async_rst_prev8",   prev8,            8'h00);
        checkOutput("async_rst_rise8",   rise8,            8'h00);
        checkOutput("async_rst_changed", {7'b0, changed8}, 8'h00);

        // An edge while still in reset must not capture.
        en = 1'b1;
        d8 = 8'h77;
        @(posedge clk);
        #1;
        checkOutput("rst_hold_q8", q8, 8'h00);

        // Release away from the edge; the next edge captures normally.
        d8 = 8'h11;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_q8",      q8,               8'h11);
        checkOutput("post_rst_prev8",   prev8,            8'h00);
        checkOutput("post_rst_rise8",   rise8,            8'h11);
        checkOutput("post_rst_changed", {7'b0, changed8}, 8'h01);

        // D moving between edges must not reach any output.
        d8 = 8'h99;
        #1;
        checkOutput("no_comb_q8",  q8,  8'h11);
        checkOutput("no_comb_qn8", qn8, 8'hEE);
        @(posedge clk);
        #1;
        checkOutput("next_q8",    q8,    8'h99);
        checkOutput("next_prev8", prev8, 8'h11);
        checkOutput("next_rise8", rise8, 8'h88);
        checkOutput("next_fall8", fall8, 8'h00);

`ifdef D_FLIPFLOP_PARITY_EN
        checkOutput("perr_clean8", {7'b0, perr8}, 8'h00);
        checkOutput("perr_clean1", {7'b0, perr1}, 8'h00);
        en      = 1'b0;
        bad_val = q8 ^ 8'h01;
        force dut8.q_reg = bad_val;
        #1;
        release dut8.q_reg;
        @(posedge clk);
        #1;
        checkOutput("perr_set8", {7'b0, perr8}, 8'h01);
        @(posedge clk);
        #1;
        checkOutput("perr_sticky8", {7'b0, perr8}, 8'h01);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("perr_clr8",   {7'b0, perr8}, 8'h00);
        checkOutput("perr_clr_q8", q8,            8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
